// File: rtl/dmem_responder.sv
// Data-memory responder: takes one-cycle write/read strobes, stalls WAIT_CYCLES, then accesses internal RAM.
// Optional DMEM_ALIGN_CHECK_EN rejects accesses whose addr[1:0] is nonzero.
module dmem_responder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable_write,
  input  logic              read_word,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              wack,
  output logic              busy,
  output logic              err
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t                  state, state_next;
  logic [3:0]              wait_cnt;
  logic                    op_write;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       mem [DEPTH];

  logic                    one_strobe, both_strobes, misaligned;
  logic                    accept, reject, enter_resp;
  logic                    access_write;
  logic [DEPTH_LOG2-1:0]   addr_idx, access_idx;
  logic [DATA_W-1:0]       access_wdata;
  logic                    unused_addr;

  assign addr_idx     = addr[DEPTH_LOG2+1:2];
  assign unused_addr  = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
  assign one_strobe   = enable_write ^ read_word;
  assign both_strobes = enable_write & read_word;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misaligned = (addr[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && one_strobe && !misaligned;
  assign reject = (state == ST_IDLE) && (both_strobes || (one_strobe && misaligned));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (wait_cnt == '0) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != ST_IDLE);
    rvalid = (state == ST_RESP) && !op_write;
    wack   = (state == ST_RESP) && op_write;
  end

  // The RAM access happens on the edge entering RESP so rdata is already valid while rvalid is high;
  // with no wait cycles that edge is the accept edge, hence the bypass of the latched request.
  always_comb begin
    access_write = op_write;
    access_idx   = idx_q;
    access_wdata = wdata_q;
    if (state == ST_IDLE) begin
      access_write = enable_write;
      access_idx   = addr_idx;
      access_wdata = wdata;
    end
    enter_resp = reset_n && (state_next == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (enter_resp && access_write) mem[access_idx] <= access_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      op_write <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      err      <= 1'b0;
      rdata    <= '0;
    end else begin
      if (accept) begin
        op_write <= enable_write;
        idx_q    <= addr_idx;
        wdata_q  <= wdata;
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      err <= reject;
      if (enter_resp && !access_write) rdata <= mem[access_idx];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with zero wait cycles, one with three.
// Expectations follow DMEM_ALIGN_CHECK_EN when the misaligned read is exercised.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w0, r0, w3, r3;
  logic [31:0] addr0, addr3, wd0, wd3;
  logic [31:0] rd0, rd3;
  logic        rv0, wk0, bz0, er0;
  logic        rv3, wk3, bz3, er3;
  logic        rst3_n;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .enable_write(w0), .read_word(r0), .addr(addr0),
    .wdata(wd0), .rdata(rd0), .rvalid(rv0), .wack(wk0), .busy(bz0), .err(er0)
  );

  dmem_responder #(.DATA_W(32), .DEPTH_LOG2(8), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(rst3_n), .enable_write(w3), .read_word(r3), .addr(addr3),
    .wdata(wd3), .rdata(rd3), .rvalid(rv3), .wack(wk3), .busy(bz3), .err(er3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Strobe is sampled at edge N; returns #1 after it, i.e. inside cycle N+1.
  task automatic req0(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    repeat (2) @(negedge clk);
    w0 = we; r0 = re; addr0 = a; wd0 = d;
    @(posedge clk); #1;
    w0 = 1'b0; r0 = 1'b0;
  endtask

  task automatic req3(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    repeat (2) @(negedge clk);
    w3 = we; r3 = re; addr3 = a; wd3 = d;
    @(posedge clk); #1;
    w3 = 1'b0; r3 = 1'b0;
  endtask

  // Walks cycles N+1..N+6 of a WAIT_CYCLES=3 access; optionally fires a stray read sampled at edge N+2.
  task automatic resp3(input logic exp_w, input logic exp_r, input logic [31:0] exp_d, input logic inject);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      check($sformatf("w3_busy_c%0d", k), {31'd0, bz3}, {31'd0, (k <= 4)});
      check($sformatf("w3_wack_c%0d", k), {31'd0, wk3}, {31'd0, (exp_w && k == 4)});
      check($sformatf("w3_rvalid_c%0d", k), {31'd0, rv3}, {31'd0, (exp_r && k == 4)});
      check($sformatf("w3_err_c%0d", k), {31'd0, er3}, 32'd0);
      if (exp_r && k == 4) check("w3_rdata", rd3, exp_d);
      if (inject && k == 2) begin r3 = 1'b1; addr3 = 32'h44; end
      if (k == 3) r3 = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; rst3_n = 1'b0;
    w0 = 1'b0; r0 = 1'b0; w3 = 1'b0; r3 = 1'b0;
    addr0 = '0; addr3 = '0; wd0 = '0; wd3 = '0;
    #12;
    check("rst_rdata0", rd0, 32'd0);
    check("rst_flags0", {28'd0, rv0, wk0, bz0, er0}, 32'd0);
    check("rst_rdata3", rd3, 32'd0);
    check("rst_flags3", {28'd0, rv3, wk3, bz3, er3}, 32'd0);
    #10;
    reset_n = 1'b1; rst3_n = 1'b1;

    // T1: write then read, next-cycle response
    req0(1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    check("t1_wack", {30'd0, wk0, rv0}, 32'b10);
    check("t1_busy", {31'd0, bz0}, 32'd1);
    req0(1'b0, 1'b1, 32'h10, 32'h0);
    check("t1_rvalid", {30'd0, wk0, rv0}, 32'b01);
    check("t1_rdata", rd0, 32'hDEADBEEF);
    @(posedge clk); #1;
    check("t1_rvalid_width", {31'd0, rv0}, 32'd0);

    // T3: both strobes -> err only, RAM untouched
    req0(1'b1, 1'b1, 32'h10, 32'h12345678);
    check("t3_err", {29'd0, er0, wk0, rv0}, 32'b100);
    check("t3_busy", {31'd0, bz0}, 32'd0);
    @(posedge clk); #1;
    check("t3_err_width", {31'd0, er0}, 32'd0);
    req0(1'b0, 1'b1, 32'h10, 32'h0);
    check("t3_readback", rd0, 32'hDEADBEEF);

    // T6: misaligned read of 0x13
    req0(1'b0, 1'b1, 32'h13, 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
    check("t6_err", {30'd0, er0, rv0}, 32'b10);
`else
    check("t6_rvalid", {30'd0, er0, rv0}, 32'b01);
`endif
    check("t6_rdata", rd0, 32'hDEADBEEF);

    // T4: index wraps modulo 256 words
    req0(1'b1, 1'b0, 32'h000, 32'h1);
    req0(1'b1, 1'b0, 32'h400, 32'h2);
    req0(1'b0, 1'b1, 32'h000, 32'h0);
    check("t4_wrap", rd0, 32'h2);
    req0(1'b1, 1'b0, 32'hFFFFFFFC, 32'hA5A5A5A5);
    check("hold_rdata_on_write", rd0, 32'h2);
    req0(1'b0, 1'b1, 32'h3FC, 32'h0);
    check("top_index", rd0, 32'hA5A5A5A5);
    req0(1'b0, 1'b1, 32'h000, 32'h0);
    check("t4_no_alias_top", rd0, 32'h2);

    // T2: stalled write then stalled read with a stray strobe mid-access
    req3(1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
    resp3(1'b1, 1'b0, 32'h0, 1'b0);
    req3(1'b0, 1'b1, 32'h20, 32'h0);
    resp3(1'b0, 1'b1, 32'hCAFEF00D, 1'b1);

    // T5: reset during WAIT of a write aborts it
    req3(1'b1, 1'b0, 32'h40, 32'h11111111);
    resp3(1'b1, 1'b0, 32'h0, 1'b0);
    req3(1'b1, 1'b0, 32'h40, 32'h22222222);
    #2;
    rst3_n = 1'b0;
    #1;
    check("t5_flags", {28'd0, rv3, wk3, bz3, er3}, 32'd0);
    check("t5_rdata", rd3, 32'd0);
    @(negedge clk);
    rst3_n = 1'b1;
    req3(1'b0, 1'b1, 32'h40, 32'h0);
    resp3(1'b0, 1'b1, 32'h11111111, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
